// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared states, stage codes and in-place address helper for the 4-bank FFT memory
package fft_pkg;

    localparam int N_PTS      = 1024;
    localparam int BANK_DEPTH = 256;

    localparam logic [2:0] ST1 = 3'b100;
    localparam logic [2:0] ST2 = 3'b101;
    localparam logic [2:0] ST3 = 3'b110;
    localparam logic [2:0] ST4 = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STAGE,
        DRAIN,
        UNLOAD
    } state_t;

    function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
        return 4'b0001 << bank;
    endfunction

    // The bank index is spliced into the 6-bit sequence index at the position
    // of the current stage's butterfly span; non-stage codes give linear order.
    function automatic logic [7:0] inplace_addr(input logic [2:0] stage,
                                                input logic [1:0] bank,
                                                input logic [5:0] idx);
        logic [7:0] a;
        case (stage)
            ST1:     a = {bank, idx};
            ST2:     a = {idx[5:4], bank, idx[3:0]};
            ST3:     a = {idx[5:2], bank, idx[1:0]};
            default: a = {idx, bank};
        endcase
        return a;
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// rtl/fft_wb_delay.sv - BF_LAT-deep valid+cnt delay line matching the butterfly latency (FFT_WB_ERR_CHK_EN adds pending)
module fft_wb_delay
    import fft_pkg::*;
#(
    parameter int BF_LAT = 6
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [10:0] in_cnt,
    output logic        out_valid,
    output logic [10:0] out_cnt
`ifdef FFT_WB_ERR_CHK_EN
    ,
    output logic        pending
`endif
);

    logic        vld_q [BF_LAT];
    logic [10:0] cnt_q [BF_LAT];

    // Advance each read tag one slot per cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < BF_LAT; i++) begin
                vld_q[i] <= 1'b0;
                cnt_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            cnt_q[0] <= in_cnt;
            for (int i = 1; i < BF_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                cnt_q[i] <= cnt_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[BF_LAT-1];
    assign out_cnt   = cnt_q[BF_LAT-1];

`ifdef FFT_WB_ERR_CHK_EN
    // Entries that have not yet reached the write-out slot.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < BF_LAT - 1; i++) begin
            pending = pending | vld_q[i];
        end
    end
`endif

endmodule

// File: rtl/fft_wb_seq.sv
// rtl/fft_wb_seq.sv - FFT sequencer and write-back address generator (optional FFT_WB_ERR_CHK_EN error flag)
module fft_wb_seq
    import fft_pkg::*;
#(
    parameter int BF_LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        busy,
    output logic        done,
    output logic [10:0] cnt,
    output logic [1:0]  mode,
    output logic        rd_en,
    output logic [3:0]  wr_en,
    output logic [7:0]  wr_addr
`ifdef FFT_WB_ERR_CHK_EN
    ,
    output logic        err
`endif
);

    localparam int            DW         = 6;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(BF_LAT - 1);

    state_t        state, state_nxt;
    logic [10:0]   cnt_nxt;
    logic [1:0]    mode_nxt;
    logic          rd_en_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic [3:0]    ld_wr_en, ld_wr_en_nxt;
    logic [7:0]    ld_wr_addr, ld_wr_addr_nxt;
    logic          drain_exit;
    logic          pipe_valid;
    logic [10:0]   pipe_cnt;
    logic [3:0]    pipe_wr_en;
    logic [7:0]    pipe_wr_addr;
`ifdef FFT_WB_ERR_CHK_EN
    logic          pending;
`endif

    assign drain_exit = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

    // State and sequencing registers; reset aborts any transform in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mode       <= 2'b00;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            drain_cnt  <= '0;
            ld_wr_en   <= 4'b0000;
            ld_wr_addr <= 8'h00;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mode       <= mode_nxt;
            rd_en      <= rd_en_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            drain_cnt  <= drain_nxt;
            ld_wr_en   <= ld_wr_en_nxt;
            ld_wr_addr <= ld_wr_addr_nxt;
        end
    end

    // Next-state logic: LOAD -> 4 x (STAGE, DRAIN) -> UNLOAD, then back to IDLE.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        mode_nxt       = mode;
        rd_en_nxt      = 1'b0;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        drain_nxt      = drain_cnt;
        ld_wr_en_nxt   = 4'b0000;
        ld_wr_addr_nxt = ld_wr_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    mode_nxt  = 2'b11;
                    busy_nxt  = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    ld_wr_en_nxt   = bank_onehot(cnt[1:0]);
                    ld_wr_addr_nxt = cnt[9:2];
                    if (cnt[9:0] == 10'(N_PTS - 1)) begin
                        state_nxt = STAGE;
                        cnt_nxt   = {ST1, 8'h00};
                        mode_nxt  = 2'b00;
                        rd_en_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 11'd1;
                    end
                end
            end
            STAGE: begin
                if (cnt[7:0] == 8'(BANK_DEPTH - 1)) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end else begin
                    cnt_nxt   = cnt + 11'd1;
                    rd_en_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_exit) begin
                    rd_en_nxt = 1'b1;
                    if (cnt[10:8] != ST4) begin
                        state_nxt = STAGE;
                        cnt_nxt   = cnt + 11'd1;
                    end else begin
                        state_nxt = UNLOAD;
                        cnt_nxt   = '0;
                    end
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end
            UNLOAD: begin
                if (cnt[7:0] == 8'(BANK_DEPTH - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + 11'd1;
                    rd_en_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    fft_wb_delay #(
        .BF_LAT (BF_LAT)
    ) u_delay (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (rd_en && (state == STAGE)),
        .in_cnt    (cnt),
        .out_valid (pipe_valid),
        .out_cnt   (pipe_cnt)
`ifdef FFT_WB_ERR_CHK_EN
        ,
        .pending   (pending)
`endif
    );

    // The stage comes from the delayed count so a write lands with its own stage's mapping.
    assign pipe_wr_en   = pipe_valid ? bank_onehot(pipe_cnt[1:0]) : 4'b0000;
    assign pipe_wr_addr = inplace_addr(pipe_cnt[10:8], pipe_cnt[1:0], pipe_cnt[7:2]);

    // LOAD and stage writes are never live together, so OR-merge is safe.
    assign wr_en   = ld_wr_en | pipe_wr_en;
    assign wr_addr = pipe_valid ? pipe_wr_addr : ld_wr_addr;

`ifdef FFT_WB_ERR_CHK_EN
    // Sticky protocol fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((start && busy) ||
                     ((wr_en & (wr_en - 4'd1)) != 4'b0000) ||
                     (drain_exit && pending)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
